// File: rtl/memguard_queue_bank.sv
// Per-requestor FIFO bank for the MemGuard scheduler: one FIFO per queue, an
// empty vector for the scheduler, and a granted head moved into one output register.
module memguard_queue_bank #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int QUEUE_DEPTH      = 8,
  parameter int DATA_WIDTH       = 64,
  localparam int SEL_W = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [NUMBER_OF_QUEUES-1:0]                  in_valid,
  output logic [NUMBER_OF_QUEUES-1:0]                  in_ready,
  output logic [NUMBER_OF_QUEUES-1:0]                  empty,
  input  logic                                         grant_valid,
  input  logic [SEL_W-1:0]                             grant_selection,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic [SEL_W-1:0]                             out_id,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         grant_error
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] storage [NUMBER_OF_QUEUES][QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr  [NUMBER_OF_QUEUES];
  logic [PTR_W-1:0]      wr_ptr  [NUMBER_OF_QUEUES];
  logic [CNT_W-1:0]      count   [NUMBER_OF_QUEUES];

  logic [NUMBER_OF_QUEUES-1:0] push;
  logic [NUMBER_OF_QUEUES-1:0] pop;
  logic                        sel_nonempty;
  logic                        out_free;
  logic                        grant_accept;
  logic [DATA_WIDTH-1:0]       head_data;

  // Status comes from registered counts only; an out-of-range selection never
  // matches a queue and so behaves like a grant to an empty queue.
  always_comb begin
    in_ready     = '0;
    empty        = '0;
    push         = '0;
    sel_nonempty = 1'b0;
    head_data    = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      in_ready[i] = (count[i] != CNT_W'(QUEUE_DEPTH));
      empty[i]    = (count[i] == '0);
      push[i]     = in_valid[i] && (count[i] != CNT_W'(QUEUE_DEPTH));
      if ((grant_selection == SEL_W'(i)) && (count[i] != '0)) begin
        sel_nonempty = 1'b1;
        head_data    = storage[i][rd_ptr[i]];
      end
    end
  end

  assign out_free     = !out_valid || out_ready;
  assign grant_accept = grant_valid && sel_nonempty && out_free;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      pop[i] = grant_accept && (grant_selection == SEL_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (push[i]) begin
        storage[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  // Pointers wrap naturally; a same-cycle push and pop leaves the count alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
      grant_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      grant_error <= grant_valid && !sel_nonempty;
      if (grant_accept) begin
        out_valid <= 1'b1;
        out_data  <= head_data;
        out_id    <= grant_selection;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memguard_queue_bank.sv
// Directed, table-driven bench for memguard_queue_bank with hand-computed
// expectations plus explicit reset sequences.
module tb_memguard_queue_bank;

  logic              clock;
  logic              reset;
  logic [3:0][63:0]  in_data;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [3:0]        empty;
  logic              grant_valid;
  logic [1:0]        grant_selection;
  logic [63:0]       out_data;
  logic [1:0]        out_id;
  logic              out_valid;
  logic              out_ready;
  logic              grant_error;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  iv;
    logic [63:0] data;
    logic        gv;
    logic [1:0]  gs;
    logic        ordy;
    logic [3:0]  e_empty;
    logic [3:0]  e_ready;
    logic        e_ov;
    logic [63:0] e_od;
    logic [1:0]  e_oid;
    logic        e_gerr;
  } vec_t;

  vec_t vecs[$];

  memguard_queue_bank #(
    .NUMBER_OF_QUEUES(4),
    .QUEUE_DEPTH(8),
    .DATA_WIDTH(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .empty(empty),
    .grant_valid(grant_valid),
    .grant_selection(grant_selection),
    .out_data(out_data),
    .out_id(out_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant_error(grant_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] iv, input logic [63:0] d,
                               input logic gv, input logic [1:0] gs, input logic ordy);
    @(negedge clock);
    reset           = rst;
    in_valid        = iv;
    in_data         = {4{d}};
    grant_valid     = gv;
    grant_selection = gs;
    out_ready       = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic checkField(input string tag, input string field, input logic [63:0] act,
                            input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_empty, input logic [3:0] e_ready,
                             input logic e_ov, input logic [63:0] e_od, input logic [1:0] e_oid,
                             input logic e_gerr);
    checkField(tag, "empty", 64'(empty), 64'(e_empty));
    checkField(tag, "in_ready", 64'(in_ready), 64'(e_ready));
    checkField(tag, "out_valid", 64'(out_valid), 64'(e_ov));
    checkField(tag, "out_data", out_data, e_od);
    checkField(tag, "out_id", 64'(out_id), 64'(e_oid));
    checkField(tag, "grant_error", 64'(grant_error), 64'(e_gerr));
  endtask

  task automatic addVec(input logic [3:0] iv, input logic [63:0] d, input logic gv, input logic [1:0] gs,
                        input logic ordy, input logic [3:0] e_empty, input logic [3:0] e_ready,
                        input logic e_ov, input logic [63:0] e_od, input logic [1:0] e_oid,
                        input logic e_gerr);
    vec_t v;
    v.iv = iv; v.data = d; v.gv = gv; v.gs = gs; v.ordy = ordy;
    v.e_empty = e_empty; v.e_ready = e_ready; v.e_ov = e_ov;
    v.e_od = e_od; v.e_oid = e_oid; v.e_gerr = e_gerr;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1; in_valid = '0; in_data = '0;
    grant_valid = 1'b0; grant_selection = '0; out_ready = 1'b0;

    // Fill queue 2 with 0x20..0x27; the eighth push makes it full.
    for (int k = 0; k < 8; k++)
      addVec(4'b0100, 64'h20 + 64'(k), 0, 0, 1, 4'b1011, (k == 7) ? 4'b1011 : 4'b1111, 0, 64'h0, 2'd0, 0);
    // Push into the full queue is refused while the first pop happens.
    addVec(4'b0100, 64'h99, 1, 2, 1, 4'b1011, 4'b1111, 1, 64'h20, 2'd2, 0);
    for (int k = 1; k < 8; k++)
      addVec(4'b0000, 64'h0, 1, 2, 1, (k == 7) ? 4'b1111 : 4'b1011, 4'b1111, 1, 64'h20 + 64'(k), 2'd2, 0);
    addVec(4'b0000, 64'h0, 0, 0, 1, 4'b1111, 4'b1111, 0, 64'h27, 2'd2, 0);
    // Backpressure on queue 0.
    addVec(4'b0001, 64'hA0, 0, 0, 0, 4'b1110, 4'b1111, 0, 64'h27, 2'd2, 0);
    addVec(4'b0001, 64'hA1, 0, 0, 0, 4'b1110, 4'b1111, 0, 64'h27, 2'd2, 0);
    addVec(4'b0000, 64'h0, 1, 0, 0, 4'b1110, 4'b1111, 1, 64'hA0, 2'd0, 0);
    for (int k = 0; k < 3; k++)
      addVec(4'b0000, 64'h0, 1, 0, 0, 4'b1110, 4'b1111, 1, 64'hA0, 2'd0, 0);
    addVec(4'b0000, 64'h0, 1, 0, 1, 4'b1111, 4'b1111, 1, 64'hA1, 2'd0, 0);
    addVec(4'b0000, 64'h0, 0, 0, 1, 4'b1111, 4'b1111, 0, 64'hA1, 2'd0, 0);
    // Grant to empty queue 3 pulses grant_error for one cycle.
    addVec(4'b0000, 64'h0, 1, 3, 0, 4'b1111, 4'b1111, 0, 64'hA1, 2'd0, 1);
    addVec(4'b0000, 64'h0, 0, 0, 0, 4'b1111, 4'b1111, 0, 64'hA1, 2'd0, 0);
    // Queue 1: three entries, then a same-cycle push and pop.
    for (int k = 0; k < 3; k++)
      addVec(4'b0010, 64'h51 + 64'(k), 0, 0, 0, 4'b1101, 4'b1111, 0, 64'hA1, 2'd0, 0);
    addVec(4'b0010, 64'h55, 1, 1, 1, 4'b1101, 4'b1111, 1, 64'h51, 2'd1, 0);
    for (int k = 0; k < 5; k++)
      addVec(4'b0010, 64'h56 + 64'(k), 0, 0, 0, 4'b1101, (k == 4) ? 4'b1101 : 4'b1111, 1, 64'h51, 2'd1, 0);
    // Full queue: the pop goes through but the push of 0x77 is refused.
    addVec(4'b0010, 64'h77, 1, 1, 1, 4'b1101, 4'b1111, 1, 64'h52, 2'd1, 0);
    begin
      logic [63:0] drain [7];
      drain = '{64'h53, 64'h55, 64'h56, 64'h57, 64'h58, 64'h59, 64'h5A};
      for (int k = 0; k < 7; k++)
        addVec(4'b0000, 64'h0, 1, 1, 1, (k == 6) ? 4'b1111 : 4'b1101, 4'b1111, 1, drain[k], 2'd1, 0);
    end
    addVec(4'b0000, 64'h0, 0, 0, 1, 4'b1111, 4'b1111, 0, 64'h5A, 2'd1, 0);

    // Reset held two cycles with random inputs.
    applyStimulus(1, 4'($urandom), {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'($urandom));
    applyStimulus(1, 4'($urandom), {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'($urandom));
    checkOutput("reset", 4'b1111, 4'b1111, 0, 64'h0, 2'd0, 0);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].iv, vecs[i].data, vecs[i].gv, vecs[i].gs, vecs[i].ordy);
      checkOutput($sformatf("row%0d", i), vecs[i].e_empty, vecs[i].e_ready, vecs[i].e_ov,
                  vecs[i].e_od, vecs[i].e_oid, vecs[i].e_gerr);
    end

    // Mid-operation reset with queues 0 and 3 non-empty and a held output.
    applyStimulus(0, 4'b0001, 64'hC0, 0, 0, 0);
    applyStimulus(0, 4'b0001, 64'hC1, 0, 0, 0);
    applyStimulus(0, 4'b1000, 64'hC3, 0, 0, 0);
    checkOutput("mid_fill", 4'b0110, 4'b1111, 0, 64'h5A, 2'd1, 0);
    applyStimulus(0, 4'b0000, 64'h0, 1, 0, 0);
    checkOutput("mid_hold", 4'b0110, 4'b1111, 1, 64'hC0, 2'd0, 0);
    applyStimulus(1, 4'b1111, 64'hEE, 1, 3, 0);
    checkOutput("mid_reset", 4'b1111, 4'b1111, 0, 64'h0, 2'd0, 0);
    applyStimulus(0, 4'b0000, 64'h0, 1, 0, 1);
    checkOutput("post_q0_gone", 4'b1111, 4'b1111, 0, 64'h0, 2'd0, 1);
    applyStimulus(0, 4'b1000, 64'hD3, 0, 0, 1);
    checkOutput("post_push", 4'b0111, 4'b1111, 0, 64'h0, 2'd0, 0);
    applyStimulus(0, 4'b0000, 64'h0, 1, 3, 1);
    checkOutput("post_grant", 4'b1111, 4'b1111, 1, 64'hD3, 2'd3, 0);
    applyStimulus(0, 4'b0000, 64'h0, 1, 3, 1);
    checkOutput("post_q3_gone", 4'b1111, 4'b1111, 0, 64'hD3, 2'd3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/memguard_queue_bank.md
# memguard_queue_bank

Per-requestor transaction buffer that sits around the MemGuard scheduler. It holds one FIFO per queue and exports the per-queue `empty` vector the scheduler consumes. It accepts the scheduler's `valid`/`selection` grant and moves the head of the selected FIFO into a single output register. That register drives the downstream memory port through a valid/ready handshake.

## Interface
- `NUMBER_OF_QUEUES`, 4: number of FIFOs; must match the scheduler.
- `QUEUE_DEPTH`, 8: entries per FIFO; power of two, ≥2.
- `DATA_WIDTH`, 64: width of one transaction descriptor.

- `clock`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  `NUMBER_OF_QUEUES`×`DATA_WIDTH`  descriptor offered to queue i.
- `in_valid`  in  `NUMBER_OF_QUEUES`  queue i offers `in_data[i]`.
- `in_ready`  out  `NUMBER_OF_QUEUES`  queue i can accept; equals count[i] < `QUEUE_DEPTH`.
- `empty`  out  `NUMBER_OF_QUEUES`  count[i] == 0; feeds the scheduler.
- `grant_valid`  in  1  scheduler grant strobe.
- `grant_selection`  in  clog2(`NUMBER_OF_QUEUES`)  queue index being granted.
- `out_data`  out  `DATA_WIDTH`  registered head descriptor.
- `out_id`  out  clog2(`NUMBER_OF_QUEUES`)  source queue of `out_data`.
- `out_valid`  out  1  output register holds a transaction.
- `out_ready`  in  1  downstream accepts the output register.
- `grant_error`  out  1  one-cycle pulse: grant to an empty queue was dropped.

## Operation
- **Per-queue state:** storage array, read pointer, write pointer (clog2(`QUEUE_DEPTH`) bits, natural wrap), and count (clog2(`QUEUE_DEPTH`)+1 bits).
- **Push i:** `in_valid[i] & in_ready[i]`. Write at the write pointer, then increment it.
- **Output register free (`out_free`):** `!out_valid | out_ready`.
- **Pop (`grant_accept`):** `grant_valid & !empty[grant_selection] & out_free`. On a pop:
  - `out_data` ← head of the selected queue.
  - `out_id` ← `grant_selection`.
  - The selected queue's read pointer increments.
- **Grant with `out_free` == 0:** ignored; no state change and no error. The scheduler re-grants.
- **Grant to an empty queue:** ignored; `grant_error` = 1 for the next cycle.
- **`out_valid`:**
  - Set by `grant_accept`.
  - Cleared when `out_valid & out_ready` and no new `grant_accept` occurs.
  - Stays 1 across back-to-back accept-and-refill.
- **Count update:** count[i] += push_i − pop_i.
  - Simultaneous push and pop on the same queue leaves count unchanged; both the data write and the head read happen.
- **Full queue:** `in_ready` is 0 whenever count == `QUEUE_DEPTH`, even if a pop occurs in the same cycle. There is no same-cycle full bypass.
- **Empty queue:** no write-to-read bypass. A descriptor pushed at cycle t is poppable no earlier than cycle t+1.
- **Combinational outputs:** `in_ready` and `empty` are derived from registered counts only. They contain no combinational path from `in_valid` or `grant_*`.
- **`grant_selection` out of range** (≥ `NUMBER_OF_QUEUES`, non-power-of-two N): treated as a grant to an empty queue.
- **Ordering:** each queue is FIFO. Inter-queue order is decided solely by the grant sequence.

## Timing
- **Reset values** (on the cycle after `reset` is sampled high):
  - all counts and pointers 0;
  - `empty` = all 1s;
  - `in_ready` = all 1s;
  - `out_valid` = 0, `out_data` = 0, `out_id` = 0;
  - `grant_error` = 0.
- **Reset mid-operation:** discards all buffered and in-flight output transactions. A held `out_valid` drops without `out_ready`. Storage contents need not be cleared.
- **Grant-to-output latency:** 1 cycle. A grant at edge t gives `out_valid` = 1 after edge t.
- **Push-to-`empty` deassert:** 1 cycle.
- **Pop-to-`empty` assert:** 1 cycle.
- **Throughput:** one pop per cycle when `out_ready` is held high, and one push per queue per cycle.
- **Downstream handshake:** `out_data` and `out_id` remain stable while `out_valid & !out_ready`.

## Test plan
- **Reset:** assert `reset` 2 cycles with random inputs.
  - → `empty` = 4'b1111, `in_ready` = 4'b1111, `out_valid` = 0, `grant_error` = 0.
- **Fill and drain queue 2:** push 8 descriptors 0x20..0x27 into queue 2.
  - → `in_ready[2]` = 0 after the 8th push.
  - Grant 2 for 8 cycles with `out_ready` = 1 → `out_data` 0x20..0x27 in order, `out_id` = 2, `empty[2]` = 1 after the last pop.
- **Backpressure:** hold `out_ready` = 0 with queue 0 holding 0xA0, 0xA1, and grant 0 three times.
  - → `out_data` stays 0xA0, count[0] = 1, no `grant_error`.
  - Raise `out_ready` with grant 0 → next `out_data` = 0xA1.
- **Empty grant:** grant queue 3 while empty.
  - → `grant_error` pulses for 1 cycle, `out_valid` unchanged, all counts unchanged.
- **Simultaneous push/pop:** queue 1 holds 3 entries; push 0x55 and grant 1 in the same cycle.
  - → count[1] stays 3, old head output.
  - At a full queue, a push with pop in the same cycle is refused (`in_ready[1]` = 0).
- **Mid-operation reset:** with 2 queues non-empty and `out_valid` = 1, assert `reset`.
  - → all outputs at reset values next cycle.
  - A subsequent push/grant returns only post-reset data.
